// File: rtl/edu_tpu_nxn.sv
// edu_tpu_nxn: Wishbone-attached N x N unsigned 8-bit matrix-vector engine with in/out FIFOs.
// Optional macro EDU_TPU_IRQ_EN adds the registered irq_o output and CTRL bit2 (irq_en).

module edu_tpu_mac #(
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [7:0]           a,
  input  logic [7:0]           b,
  output logic [ACC_WIDTH-1:0] acc
);
  logic [15:0] prod;
  assign prod = {8'd0, a} * {8'd0, b};

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + ACC_WIDTH'(prod);
  end
endmodule

module edu_tpu_nxn #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          ARRAY_SIZE   = 3,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          ACC_WIDTH    = 20
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_adr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o
`ifdef EDU_TPU_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int N         = ARRAY_SIZE;
  localparam int VW        = 8 * N;
  localparam int OUT_DEPTH = FIFO_DEPTH * N;
  localparam int IPW       = $clog2(FIFO_DEPTH);
  localparam int OPW       = $clog2(OUT_DEPTH);
  localparam int KW        = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  logic clk, rst;
  assign clk = caravel_wb_clk_i;
  assign rst = caravel_wb_rst_i;

  // Bus decode
  logic       hit, req, wr, rd;
  logic [2:0] off;
  assign hit = caravel_wb_adr_i[31:5] == BASE_ADDRESS[31:5];
  assign off = caravel_wb_adr_i[4:2];
  assign req = caravel_wb_stb_i && caravel_wb_cyc_i && hit && !caravel_wb_ack_o;
  assign wr  = req && caravel_wb_we_i;
  assign rd  = req && !caravel_wb_we_i;

  logic unused_ok;
  assign unused_ok = ^{caravel_wb_sel_i, caravel_wb_adr_i[1:0], caravel_wb_dat_i};

  logic soft_clr;
  assign soft_clr = wr && off == 3'd0 && caravel_wb_dat_i[1];

  // Architectural state
  state_t                    state;
  logic [KW-1:0]             k, wptr;
  logic [N-1:0][N-1:0][7:0]  w;
  logic [N-1:0][7:0]         x;
  logic                      run, ovf, wgt_err;
`ifdef EDU_TPU_IRQ_EN
  logic                      irq_en;
`endif

  logic [VW-1:0]             in_mem [FIFO_DEPTH];
  logic [IPW-1:0]            in_wp, in_rp;
  logic [IPW:0]              in_cnt;
  logic [ACC_WIDTH-1:0]      out_mem [OUT_DEPTH];
  logic [OPW-1:0]            out_wp, out_rp;
  logic [OPW:0]              out_cnt;

  logic in_full, in_empty, out_full, out_empty, busy;
  assign in_full   = in_cnt == (IPW+1)'(FIFO_DEPTH);
  assign in_empty  = in_cnt == '0;
  assign out_full  = out_cnt == (OPW+1)'(OUT_DEPTH);
  assign out_empty = out_cnt == '0;
  assign busy      = state != IDLE;

  logic in_push, in_pop, in_ovf, out_push, out_pop, start, acc_en, k_last;
  assign in_push  = wr && off == 3'd3 && !in_full;
  assign in_ovf   = wr && off == 3'd3 && in_full;
  // Only start when the whole result vector is guaranteed a slot in the output FIFO.
  assign start    = state == IDLE && run && !in_empty && !soft_clr &&
                    int'(out_cnt) <= OUT_DEPTH - N;
  assign in_pop   = start;
  assign out_push = state == DRAIN;
  assign out_pop  = rd && off == 3'd4 && !out_empty;
  assign acc_en   = (state == LOAD || state == COMPUTE) && !soft_clr;
  assign k_last   = k == KW'(N - 1);

  // One MAC lane per output column; all lanes consume x[k] in step k.
  logic [N-1:0][ACC_WIDTH-1:0] acc;
  for (genvar j = 0; j < N; j++) begin : g_lane
    edu_tpu_mac #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (acc_en),
      .a   (x[k]),
      .b   (w[k][j]),
      .acc (acc[j])
    );
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (off)
      3'd0: begin
        rdata[0] = run;
`ifdef EDU_TPU_IRQ_EN
        rdata[2] = irq_en;
`endif
      end
      3'd1: begin
        rdata[0]     = busy;
        rdata[1]     = in_full;
        rdata[2]     = in_empty;
        rdata[3]     = out_full;
        rdata[4]     = out_empty;
        rdata[5]     = ovf;
        rdata[6]     = wgt_err;
        rdata[15:8]  = 8'(in_cnt);
        rdata[23:16] = 8'(out_cnt);
      end
      3'd4: if (!out_empty) rdata = 32'(out_mem[out_rp]);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      caravel_wb_ack_o <= 1'b0;
      caravel_wb_dat_o <= '0;
      state   <= IDLE;
      k       <= '0;
      wptr    <= '0;
      w       <= '0;
      x       <= '0;
      run     <= 1'b0;
      ovf     <= 1'b0;
      wgt_err <= 1'b0;
`ifdef EDU_TPU_IRQ_EN
      irq_en  <= 1'b0;
`endif
      in_wp   <= '0;
      in_rp   <= '0;
      in_cnt  <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) in_mem[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++)  out_mem[i] <= '0;
    end else begin
      caravel_wb_ack_o <= req;
      caravel_wb_dat_o <= rd ? rdata : '0;

      if (wr && off == 3'd0) begin
        run <= caravel_wb_dat_i[0];
`ifdef EDU_TPU_IRQ_EN
        irq_en <= caravel_wb_dat_i[2];
`endif
      end
      if (wr && off == 3'd1) begin
        if (caravel_wb_dat_i[5]) ovf     <= 1'b0;
        if (caravel_wb_dat_i[6]) wgt_err <= 1'b0;
      end
      if (wr && off == 3'd2) begin
        if (busy) wgt_err <= 1'b1;
        else begin
          w[wptr] <= caravel_wb_dat_i[VW-1:0];
          wptr    <= (wptr == KW'(N - 1)) ? '0 : wptr + KW'(1);
        end
      end
      if (in_ovf) ovf <= 1'b1;

      if (in_push) begin
        in_mem[in_wp] <= caravel_wb_dat_i[VW-1:0];
        in_wp         <= in_wp + IPW'(1);
      end
      if (in_pop) in_rp <= in_rp + IPW'(1);
      in_cnt <= in_cnt + (IPW+1)'(in_push) - (IPW+1)'(in_pop);

      // Output FIFO depth need not be a power of two, so pointers wrap explicitly.
      if (out_push) begin
        out_mem[out_wp] <= acc[k];
        out_wp <= (out_wp == OPW'(OUT_DEPTH - 1)) ? '0 : out_wp + OPW'(1);
      end
      if (out_pop) out_rp <= (out_rp == OPW'(OUT_DEPTH - 1)) ? '0 : out_rp + OPW'(1);
      out_cnt <= out_cnt + (OPW+1)'(out_push) - (OPW+1)'(out_pop);

      case (state)
        IDLE: if (start) begin
          x     <= in_mem[in_rp];
          k     <= '0;
          state <= LOAD;
        end
        LOAD, COMPUTE: begin
          k     <= k_last ? '0 : k + KW'(1);
          state <= k_last ? DRAIN : COMPUTE;
        end
        DRAIN: begin
          k <= k_last ? '0 : k + KW'(1);
          if (k_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (soft_clr) begin
        state   <= IDLE;
        k       <= '0;
        wptr    <= '0;
        ovf     <= 1'b0;
        wgt_err <= 1'b0;
        in_wp   <= '0;
        in_rp   <= '0;
        in_cnt  <= '0;
        out_wp  <= '0;
        out_rp  <= '0;
        out_cnt <= '0;
      end
    end
  end

`ifdef EDU_TPU_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq_o <= 1'b0;
    else     irq_o <= irq_en && !out_empty;
  end
`endif

endmodule

// File: tb/tb_edu_tpu_nxn.sv
// Bench for edu_tpu_nxn (N=3, FIFO_DEPTH=4): table vectors, directed corner cases, random vs model.
module tb_edu_tpu_nxn;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst, stb, cyc, we, ack;
  logic [3:0]  sel;
  logic [31:0] dati, adr, dato;
`ifdef EDU_TPU_IRQ_EN
  logic        irq;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edu_tpu_nxn #(.BASE_ADDRESS(BASE), .ARRAY_SIZE(3), .FIFO_DEPTH(4), .ACC_WIDTH(20)) dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .caravel_wb_stb_i (stb),
    .caravel_wb_cyc_i (cyc),
    .caravel_wb_we_i  (we),
    .caravel_wb_sel_i (sel),
    .caravel_wb_dat_i (dati),
    .caravel_wb_adr_i (adr),
    .caravel_wb_ack_o (ack),
    .caravel_wb_dat_o (dato)
`ifdef EDU_TPU_IRQ_EN
    ,
    .irq_o            (irq)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge on which ack is seen.
  task automatic wb(input logic w, input logic [7:0] off, input logic [31:0] d,
                    output logic [31:0] q);
    bit got = 0;
    q   = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + 32'(off); dati = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) begin got = 1; q = dato; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("bus_ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] q;
    wb(1'b1, off, d, q);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] q);
    wb(1'b0, off, 32'd0, q);
  endtask

  task automatic wait_done(input int n);
    logic [31:0] s;
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      rd(8'h04, s);
      if (!s[0] && int'(s[23:16]) == n) begin ok = 1; break; end
    end
    check("wait_done", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [23:0] w0, w1, w2, x;
    logic [19:0] y0, y1, y2;
  } tv_t;
  tv_t tv[4];

  int          wm[3][3];
  int          xv[3];
  logic [19:0] exp_q[$];

  initial begin
    logic [31:0] q, s, row, vec;
    int nacks, consec, prev_ack, dsum, sum;

    tv[0] = '{24'h000001, 24'h000100, 24'h010000, 24'h030201, 20'd1, 20'd2, 20'd3};
    tv[1] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 20'h2FA03, 20'h2FA03, 20'h2FA03};
    tv[2] = '{24'h030201, 24'h000000, 24'h010101, 24'h050002, 20'd7, 20'd9, 20'd11};
    tv[3] = '{24'h0A0B0C, 24'h010203, 24'h000000, 24'h000201, 20'd18, 20'd15, 20'd12};

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; dati = '0; adr = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", dato, 32'd0);
    rst = 1'b0;
    rd(8'h00, q); check("reset_ctrl", q, 32'd0);
    rd(8'h04, q); check("reset_status", q, 32'h14);

    // Table-driven vectors
    foreach (tv[i]) begin
      wr(8'h00, 32'h2);
      wr(8'h08, 32'(tv[i].w0)); wr(8'h08, 32'(tv[i].w1)); wr(8'h08, 32'(tv[i].w2));
      wr(8'h00, 32'h1);
      wr(8'h0C, 32'(tv[i].x));
      wait_done(3);
      rd(8'h10, q); check($sformatf("tv%0d_y0", i), q, 32'(tv[i].y0));
      rd(8'h10, q); check($sformatf("tv%0d_y1", i), q, 32'(tv[i].y1));
      rd(8'h10, q); check($sformatf("tv%0d_y2", i), q, 32'(tv[i].y2));
    end

    // Identity latency: first result pushed 5 edges after the INPUT ack edge
    wr(8'h00, 32'h2);
    wr(8'h08, 32'h000001); wr(8'h08, 32'h000100); wr(8'h08, 32'h010000);
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'h030201);
    repeat (5) @(negedge clk);
    rd(8'h04, s); check("latency_status_e5", s, 32'h0001_0005);
    wait_done(3);
    rd(8'h10, q); check("ident_y0", q, 32'd1);
    rd(8'h10, q); check("ident_y1", q, 32'd2);
    rd(8'h10, q); check("ident_y2", q, 32'd3);
    rd(8'h10, q); check("result_empty_read", q, 32'd0);
    // One vector takes 2N+1 cycles: idle after edge E0+7 with all three pushed
    wr(8'h0C, 32'h010101);
    repeat (7) @(negedge clk);
    rd(8'h04, s); check("latency_status_e7", s, 32'h0003_0004);
    for (int j = 0; j < 3; j++) begin
      rd(8'h10, q); check("ident_ones", q, 32'd1);
    end

    // WEIGHT write while busy is ignored and flags wgt_err
    wr(8'h0C, 32'h030201);
    repeat (2) @(negedge clk);
    wr(8'h08, 32'hFFFFFF);
    rd(8'h04, s); check("wgt_err_set", 32'(s[6]), 32'd1);
    wait_done(3);
    rd(8'h10, q); check("wgt_err_y0", q, 32'd1);
    rd(8'h10, q); check("wgt_err_y1", q, 32'd2);
    rd(8'h10, q); check("wgt_err_y2", q, 32'd3);
    wr(8'h04, 32'h40);
    rd(8'h04, s); check("wgt_err_clear", 32'(s[6]), 32'd0);

    // soft_clear in mid-COMPUTE
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h030201); wr(8'h0C, 32'h030201);
    wr(8'h00, 32'h1);
    repeat (2) @(negedge clk);
    wr(8'h00, 32'h2);
    rd(8'h04, s); check("soft_clear_status", s, 32'h14);

    // Held strobe on an unmapped offset: alternate-cycle acks, data 0
    nacks = 0; consec = 0; prev_ack = 0; dsum = 0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h1C;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack) begin
        nacks++;
        if (prev_ack != 0) consec++;
        dsum = dsum | int'(dato);
      end
      prev_ack = int'(ack);
    end
    stb = 1'b0; cyc = 1'b0;
    check("held_stb_acks", 32'(nacks), 32'd2);
    check("held_stb_consec", 32'(consec), 32'd0);
    check("unmapped_read", 32'(dsum), 32'd0);
    @(negedge clk);

    // CTRL readback: irq_en exists only with the IRQ build
    wr(8'h00, 32'h5);
    rd(8'h00, q);
`ifdef EDU_TPU_IRQ_EN
    check("ctrl_readback", q, 32'h5);
    check("irq_idle", 32'(irq), 32'd0);
    wr(8'h0C, 32'h030201);
    wait_done(3);
    check("irq_high", 32'(irq), 32'd1);
    rd(8'h10, q); rd(8'h10, q);
    check("irq_before_last_pop", 32'(irq), 32'd1);
    rd(8'h10, q);
    @(negedge clk);
    check("irq_low", 32'(irq), 32'd0);
`else
    check("ctrl_readback", q, 32'h1);
`endif

    // Random rounds against the arithmetic model
    for (int r = 0; r < 3; r++) begin
      int pushes, occ;
      wr(8'h00, 32'h2);
      for (int k = 0; k < 3; k++) begin
        row = '0;
        for (int j = 0; j < 3; j++) begin
          wm[k][j] = int'($urandom_range(0, 255));
          row = row | (32'(wm[k][j]) << (8 * j));
        end
        wr(8'h08, row);
      end
      pushes = (r == 0) ? 5 : 4;
      occ = 0;
      for (int v = 0; v < pushes; v++) begin
        vec = $urandom;
        for (int k = 0; k < 3; k++) xv[k] = int'((vec >> (8 * k)) & 32'hFF);
        wr(8'h0C, vec);
        if (occ < 4) begin
          occ++;
          for (int j = 0; j < 3; j++) begin
            sum = 0;
            for (int k = 0; k < 3; k++) sum += xv[k] * wm[k][j];
            exp_q.push_back(20'(sum));
          end
        end
      end
      if (r == 0) begin
        rd(8'h04, s); check("overflow_status", s, 32'h0000_0432);
        wr(8'h04, 32'h20);
        rd(8'h04, s); check("overflow_cleared", s, 32'h0000_0412);
      end
      wr(8'h00, 32'h1);
      wait_done(12);
      while (exp_q.size() > 0) begin
        rd(8'h10, q);
        check($sformatf("rand%0d_result", r), q, 32'(exp_q.pop_front()));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, want finish");
    $fatal(1, "timeout");
  end
endmodule
